reg_file_8x16: RTL and testbench
================================

Name: reg_file_8x16

Overview:
- Eight-entry register file that directly consumes the one-hot write-select vector produced by the 3-to-8 write-address decoder.
- Provides two combinational read ports (A and B) for the datapath ALU operands.
- Tracks per-register "written since reset" status.
- Flags any write-select vector that is not one-hot as a sticky error, and suppresses the write when that happens.

Parameters:
- DATA_W, 16, width of each register and of the data ports.
- BYPASS, 1, 1 = a read of the register being written in the same cycle returns w_data; 0 = it returns the stored (old) value.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- we_onehot  input  8  write select from decoder; bit i writes register Ri; all-zero = no write.
- w_data  input  DATA_W  write data.
- r_addr_a  input  3  read address, port A.
- r_addr_b  input  3  read address, port B.
- clr_err  input  1  synchronous clear of onehot_err.
- rd_a  output  DATA_W  read data, port A (combinational).
- rd_b  output  DATA_W  read data, port B (combinational).
- reg_valid  output  8  bit i = 1 once Ri has been legally written since reset.
- onehot_err  output  1  sticky flag: a multi-hot we_onehot was presented.

Behaviour:
- Reset (reset == 0 at a rising clk):
  - R0..R7 <= 0, reg_valid <= 8'h00, onehot_err <= 0.
  - Reset overrides every write and clear presented in the same cycle.
  - Reset asserted mid-sequence discards any write in that cycle.
- Write classification (per rising clk with reset == 1):
  - we_onehot == 8'h00: idle. No register change.
  - Exactly one bit i set: Ri <= w_data; reg_valid[i] <= 1. Takes effect at this edge; visible on the read ports immediately after.
  - Two or more bits set: illegal. No register and no reg_valid bit changes; onehot_err <= 1.
  - Popcount is evaluated combinationally over all 8 bits.
- onehot_err:
  - Set by an illegal vector and held until reset, or until clr_err == 1 at an edge with no illegal vector.
  - Same-edge illegal vector and clr_err: set wins, so onehot_err stays 1.
- Reads:
  - Purely combinational, zero-cycle latency.
  - rd_a = R[r_addr_a]; rd_b = R[r_addr_b]. Both ports may address the same register.
- Bypass:
  - BYPASS == 1 and a legal write targets Ri: any port addressing i outputs w_data in that same cycle (before the edge).
  - Illegal vectors never bypass.
  - BYPASS == 0: ports always show stored contents.
- Timing: no handshake. A write completes in 1 cycle; back-to-back writes to the same or different registers are allowed every cycle.
- Width: w_data is stored unmodified at DATA_W bits. No sign or zero extension.
- Unused decoder-disabled cycles (all-zero vector) are normal idle and are never errors.

Test Plan:
1. Reset held low 2 cycles with we_onehot = 8'hFF, w_data = 16'hBEEF -> all eight reads = 16'h0000, reg_valid = 8'h00, onehot_err = 0.
2. Sequential writes 8'h01..8'h80, with w_data = 16'h1111 * (i+1) into Ri (i = 0..7) -> each reads back with correct value on both ports; reg_valid = 8'hFF after the 8th edge.
3. BYPASS = 1: R3 = 16'h00AA, then we_onehot = 8'h08, w_data = 16'h5555, r_addr_a = 3, r_addr_b = 3 -> rd_a = rd_b = 16'h5555 before the edge; with BYPASS = 0, both read 16'h00AA until after the edge.
4. R2 = 16'h1234, then we_onehot = 8'h24, w_data = 16'hFFFF -> R2 stays 16'h1234, R5 unchanged, reg_valid[5] unchanged, onehot_err = 1 after the edge and stays 1 for 10 idle cycles.
5. With onehot_err = 1: clr_err = 1 together with we_onehot = 8'h03 -> onehot_err stays 1. Next cycle clr_err = 1, we_onehot = 8'h00 -> onehot_err = 0.
6. Mid-stream reset: write R7 = 16'hCAFE, then reset = 0 in the same cycle as we_onehot = 8'h40 -> R6 = R7 = 16'h0000 and reg_valid = 8'h00 after the edge.

Source files
------------

// File: rtl/reg_file_8x16.sv
// Eight-entry register file written by a one-hot select vector, with two
// combinational read ports.
// Inputs: clk, reset (active low), we_onehot, w_data, r_addr_a, r_addr_b,
// clr_err.
// Outputs: rd_a, rd_b, reg_valid, onehot_err.
// A select vector with more than one bit set blocks the write and raises
// the sticky onehot_err flag.
module reg_file_8x16 #(
  parameter int unsigned DATA_W = 16,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        we_onehot,
  input  logic [DATA_W-1:0] w_data,
  input  logic [2:0]        r_addr_a,
  input  logic [2:0]        r_addr_b,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic [7:0]        reg_valid,
  output logic              onehot_err
);

  logic [DATA_W-1:0] mem_q [8];
  logic [DATA_W-1:0] mem_d [8];
  logic [7:0]        valid_q, valid_d;
  logic              err_q, err_d;

  logic [3:0] ones;
  logic [2:0] wr_idx;
  logic       wr_legal;
  logic       wr_illegal;

  always_comb begin
    ones   = '0;
    wr_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      ones = ones + 4'(we_onehot[i]);
      if (we_onehot[i]) wr_idx = 3'(i);
    end
    wr_legal   = (ones == 4'd1);
    wr_illegal = (ones > 4'd1);
  end

  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (wr_legal) begin
      mem_d[wr_idx]   = w_data;
      valid_d[wr_idx] = 1'b1;
    end
    // An illegal vector outranks a same-cycle clear.
    if (wr_illegal)   err_d = 1'b1;
    else if (clr_err) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q   <= '{default: '0};
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    rd_a = mem_q[r_addr_a];
    rd_b = mem_q[r_addr_b];
    if (BYPASS && wr_legal && (wr_idx == r_addr_a)) rd_a = w_data;
    if (BYPASS && wr_legal && (wr_idx == r_addr_b)) rd_b = w_data;
  end

  assign reg_valid  = valid_q;
  assign onehot_err = err_q;

endmodule

// File: tb/tb_reg_file_8x16.sv
module tb_reg_file_8x16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  we;
  logic [15:0] wd;
  logic [2:0]  ra, rb;
  logic        clr;

  logic [15:0] rd_a1, rd_b1, rd_a0, rd_b0;
  logic [7:0]  val1, val0;
  logic        err1, err0;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [15:0] m_reg [8];
  logic [7:0]  m_valid;
  logic        m_err;

  always #5 clk = ~clk;

  reg_file_8x16 #(.DATA_W(16), .BYPASS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .we_onehot(we), .w_data(wd),
    .r_addr_a(ra), .r_addr_b(rb), .clr_err(clr),
    .rd_a(rd_a1), .rd_b(rd_b1), .reg_valid(val1), .onehot_err(err1)
  );

  reg_file_8x16 #(.DATA_W(16), .BYPASS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .we_onehot(we), .w_data(wd),
    .r_addr_a(ra), .r_addr_b(rb), .clr_err(clr),
    .rd_a(rd_a0), .rd_b(rd_b0), .reg_valid(val0), .onehot_err(err0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: registers as a plain array, updated from the rules.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
      m_valid = 8'h00;
      m_err   = 1'b0;
    end else begin
      if ($countones(we) == 1) begin
        m_reg[$clog2(we)]   = wd;
        m_valid[$clog2(we)] = 1'b1;
      end
      if ($countones(we) > 1) m_err = 1'b1;
      else if (clr)           m_err = 1'b0;
    end
  end

  function automatic logic [15:0] exp_rd(input logic [2:0] a, input bit byp);
    if (byp && $countones(we) == 1 && we[a]) return wd;
    return m_reg[a];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_b1", {24'h0, val1}, {24'h0, m_valid});
      chk("valid_b0", {24'h0, val0}, {24'h0, m_valid});
      chk("err_b1", {31'h0, err1}, {31'h0, m_err});
      chk("err_b0", {31'h0, err0}, {31'h0, m_err});
      if (reset) begin
        chk("rd_a_b1", {16'h0, rd_a1}, {16'h0, exp_rd(ra, 1'b1)});
        chk("rd_b_b1", {16'h0, rd_b1}, {16'h0, exp_rd(rb, 1'b1)});
        chk("rd_a_b0", {16'h0, rd_a0}, {16'h0, exp_rd(ra, 1'b0)});
        chk("rd_b_b0", {16'h0, rd_b0}, {16'h0, exp_rd(rb, 1'b0)});
      end
    end
  end

  task automatic drive(input logic r, input logic [7:0] w, input logic [15:0] d,
                       input logic [2:0] a, input logic [2:0] b, input logic c);
    @(posedge clk);
    #1;
    reset = r; we = w; wd = d; ra = a; rb = b; clr = c;
  endtask

  initial begin
    reset = 1'b0; we = 8'hFF; wd = 16'hBEEF; ra = '0; rb = '0; clr = 1'b0;

    // Reset held two cycles with a full-ones select.
    drive(1'b0, 8'hFF, 16'hBEEF, 3'd0, 3'd7, 1'b0);
    chk_en = 1'b1;
    drive(1'b0, 8'hFF, 16'hBEEF, 3'd1, 3'd6, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'h00, 16'hBEEF, 3'(i), 3'(7 - i), 1'b0);
      #1;
      chk("rst_rd_a", {16'h0, rd_a1}, 32'h0);
      chk("rst_rd_b", {16'h0, rd_b0}, 32'h0);
    end
    chk("rst_valid", {24'h0, val1}, 32'h0);
    chk("rst_err", {31'h0, err1}, 32'h0);

    // Sequential writes into every register.
    for (int i = 0; i < 8; i++)
      drive(1'b1, 8'(1 << i), 16'(16'h1111 * (i + 1)), 3'(i), 3'(i), 1'b0);
    drive(1'b1, 8'h00, 16'h0000, 3'd4, 3'd7, 1'b0);
    #1;
    chk("seq_valid", {24'h0, val1}, 32'h0000_00FF);
    chk("seq_r4", {16'h0, rd_a0}, 32'h0000_5555);
    chk("seq_r7", {16'h0, rd_b1}, 32'h0000_8888);

    // Bypass versus stored value.
    drive(1'b1, 8'h08, 16'h00AA, 3'd3, 3'd3, 1'b0);
    drive(1'b1, 8'h08, 16'h5555, 3'd3, 3'd3, 1'b0);
    #1;
    chk("byp1_a", {16'h0, rd_a1}, 32'h0000_5555);
    chk("byp1_b", {16'h0, rd_b1}, 32'h0000_5555);
    chk("byp0_a", {16'h0, rd_a0}, 32'h0000_00AA);
    chk("byp0_b", {16'h0, rd_b0}, 32'h0000_00AA);
    drive(1'b1, 8'h00, 16'h0000, 3'd3, 3'd3, 1'b0);
    #1;
    chk("byp0_after", {16'h0, rd_a0}, 32'h0000_5555);

    // Multi-hot select blocks the write and raises the flag.
    drive(1'b1, 8'h04, 16'h1234, 3'd2, 3'd5, 1'b0);
    drive(1'b1, 8'h24, 16'hFFFF, 3'd2, 3'd5, 1'b0);
    #1;
    chk("ill_nobyp", {16'h0, rd_a1}, 32'h0000_1234);
    drive(1'b1, 8'h00, 16'h0000, 3'd2, 3'd5, 1'b0);
    #1;
    chk("ill_r2", {16'h0, rd_a1}, 32'h0000_1234);
    chk("ill_r5", {16'h0, rd_b1}, 32'h0000_6666);
    chk("ill_valid5", {31'h0, val1[5]}, 32'h1);
    chk("ill_err", {31'h0, err1}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'h00, 16'h0000, 3'd2, 3'd5, 1'b0);
      #1;
      chk("ill_err_hold", {31'h0, err0}, 32'h1);
    end

    // Clear loses to a simultaneous illegal vector.
    drive(1'b1, 8'h03, 16'h0F0F, 3'd0, 3'd1, 1'b1);
    drive(1'b1, 8'h00, 16'h0000, 3'd0, 3'd1, 1'b1);
    #1;
    chk("clr_lose", {31'h0, err1}, 32'h1);
    chk("clr_r0", {16'h0, rd_a1}, 32'h0000_1111);
    drive(1'b1, 8'h00, 16'h0000, 3'd0, 3'd1, 1'b0);
    #1;
    chk("clr_win", {31'h0, err1}, 32'h0);

    // Reset in the middle of traffic.
    drive(1'b1, 8'h80, 16'hCAFE, 3'd7, 3'd6, 1'b0);
    drive(1'b0, 8'h40, 16'h7777, 3'd7, 3'd6, 1'b0);
    drive(1'b1, 8'h00, 16'h0000, 3'd6, 3'd7, 1'b0);
    #1;
    chk("mid_r6", {16'h0, rd_a1}, 32'h0);
    chk("mid_r7", {16'h0, rd_b1}, 32'h0);
    chk("mid_valid", {24'h0, val1}, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      automatic int unsigned sel = $urandom_range(0, 99);
      automatic logic [7:0]  w;
      if (sel < 50)      w = 8'(1 << $urandom_range(0, 7));
      else if (sel < 75) w = 8'h00;
      else               w = 8'($urandom_range(0, 255));
      drive(($urandom_range(0, 99) >= 3), w, 16'($urandom()),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 9) == 0));
    end
    drive(1'b1, 8'h00, 16'h0000, 3'd0, 3'd0, 1'b0);
    @(negedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
